// File: rtl/gbe_status_packer_if.sv
// rtl/gbe_status_packer_if.sv - 10GbE core strobes in, packed status word out
interface gbe_status_packer_if;
    logic        link_up_raw;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic        tx_overflow;
    logic        tx_afull;
    logic        rx_valid;
    logic        rx_end_of_frame;
    logic        rx_bad_frame;
    logic        rx_overrun;
    logic        sw_clr;
    logic        link_ok;
    logic [31:0] status_word;

    modport master (
        output link_up_raw, tx_valid, tx_end_of_frame, tx_overflow, tx_afull,
        output rx_valid, rx_end_of_frame, rx_bad_frame, rx_overrun, sw_clr,
        input  link_ok, status_word
    );

    modport slave (
        input  link_up_raw, tx_valid, tx_end_of_frame, tx_overflow, tx_afull,
        input  rx_valid, rx_end_of_frame, rx_bad_frame, rx_overrun, sw_clr,
        output link_ok, status_word
    );
endinterface

// File: rtl/gbe_status_packer.sv
// rtl/gbe_status_packer.sv - debounced link, sticky flags, saturating counters, periodic snapshot
module gbe_status_packer #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REFRESH_CYCLES  = 256
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    gbe_status_packer_if.slave bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_DOWN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_UP       = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_deb_cnt;
    logic [DW-1:0]  w_deb_cnt_nxt;
    logic           w_flap_evt;
    logic           r_link_ok;

    logic           r_sw_clr_d;
    logic           w_clr_edge;
    logic           w_tx_evt;
    logic           w_rx_evt;
    logic           w_rx_bad_evt;

    logic [11:0]    r_tx_cnt;
    logic [11:0]    r_rx_cnt;
    logic [2:0]     r_flap_cnt;
    logic           r_tx_ovf_s;
    logic           r_rx_ovr_s;
    logic           r_rx_bad_s;
    logic           r_tx_afull_s;

    logic [RW-1:0]  r_ref_cnt;
    logic           w_wrap;
    logic           r_force_snap;
    logic [31:0]    w_packed;
    logic [31:0]    r_status_word;

    assign w_clr_edge   = bus.sw_clr & ~r_sw_clr_d;
    assign w_tx_evt     = bus.tx_valid & bus.tx_end_of_frame;
    assign w_rx_evt     = bus.rx_valid & bus.rx_end_of_frame;
    assign w_rx_bad_evt = w_rx_evt & bus.rx_bad_frame;
    assign w_wrap       = (r_ref_cnt == REF_LAST);

    // Link loss is taken immediately; only link gain is debounced.
    always_comb begin
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_flap_evt    = 1'b0;
        case (r_state)
            ST_DOWN: begin
                if (bus.link_up_raw) begin
                    w_state_nxt   = ST_DEBOUNCE;
                    w_deb_cnt_nxt = DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!bus.link_up_raw) begin
                    w_state_nxt   = ST_DOWN;
                    w_deb_cnt_nxt = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt   = ST_UP;
                    w_deb_cnt_nxt = '0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + DW'(1);
                end
            end
            ST_UP: begin
                if (!bus.link_up_raw) begin
                    w_state_nxt = ST_DOWN;
                    w_flap_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_DOWN;
                w_deb_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state   <= ST_DOWN;
            r_deb_cnt <= '0;
            r_link_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
            r_link_ok <= (w_state_nxt == ST_UP);
        end
    end

    // A clear edge takes priority over any event arriving in the same cycle.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_sw_clr_d   <= 1'b0;
            r_tx_cnt     <= '0;
            r_rx_cnt     <= '0;
            r_flap_cnt   <= '0;
            r_tx_ovf_s   <= 1'b0;
            r_rx_ovr_s   <= 1'b0;
            r_rx_bad_s   <= 1'b0;
            r_tx_afull_s <= 1'b0;
        end else begin
            r_sw_clr_d <= bus.sw_clr;
            if (w_clr_edge) begin
                r_tx_cnt     <= '0;
                r_rx_cnt     <= '0;
                r_flap_cnt   <= '0;
                r_tx_ovf_s   <= 1'b0;
                r_rx_ovr_s   <= 1'b0;
                r_rx_bad_s   <= 1'b0;
                r_tx_afull_s <= 1'b0;
            end else begin
                if (w_tx_evt && (r_tx_cnt != 12'hFFF)) begin
                    r_tx_cnt <= r_tx_cnt + 12'd1;
                end
                if (w_rx_evt && (r_rx_cnt != 12'hFFF)) begin
                    r_rx_cnt <= r_rx_cnt + 12'd1;
                end
                if (w_flap_evt && (r_flap_cnt != 3'd7)) begin
                    r_flap_cnt <= r_flap_cnt + 3'd1;
                end
                if (bus.tx_overflow) r_tx_ovf_s   <= 1'b1;
                if (bus.rx_overrun)  r_rx_ovr_s   <= 1'b1;
                if (w_rx_bad_evt)    r_rx_bad_s   <= 1'b1;
                if (bus.tx_afull)    r_tx_afull_s <= 1'b1;
            end
        end
    end

    assign w_packed = {(r_state == ST_UP), r_tx_ovf_s, r_rx_ovr_s, r_rx_bad_s,
                       r_tx_afull_s, r_flap_cnt, r_tx_cnt, r_rx_cnt};

    // After a clear, the forced snapshot publishes the zeroed state one cycle later.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_ref_cnt     <= '0;
            r_force_snap  <= 1'b0;
            r_status_word <= '0;
        end else begin
            r_force_snap <= w_clr_edge;
            if (w_clr_edge || w_wrap) begin
                r_ref_cnt <= '0;
            end else begin
                r_ref_cnt <= r_ref_cnt + RW'(1);
            end
            if (w_wrap || r_force_snap) begin
                r_status_word <= w_packed;
            end
        end
    end

    assign bus.link_ok     = r_link_ok;
    assign bus.status_word = r_status_word;

endmodule

// File: tb/tb_gbe_status_packer.sv
// tb/tb_gbe_status_packer.sv - directed checks of gbe_status_packer
module tb_gbe_status_packer;

    logic user_clk;
    logic user_rst_n;
    int   n_checks;
    int   n_pass;
    int   n;

    gbe_status_packer_if bus ();

    gbe_status_packer #(
        .DEBOUNCE_CYCLES(16),
        .REFRESH_CYCLES (8)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .bus       (bus)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Returns the number of edges until link_ok is seen high, 0 on timeout.
    task automatic wait_link(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.link_ok === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Reset pulse placed away from the clock edge; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        user_rst_n = 1'b0;
        #1;
        check({tag, "_link_ok"}, {31'd0, bus.link_ok}, 32'd0);
        check({tag, "_status"}, bus.status_word, 32'd0);
        #9;
        user_rst_n = 1'b1;
    endtask

    task automatic tx_eof(input logic v);
        bus.tx_valid        = v;
        bus.tx_end_of_frame = v;
    endtask

    initial begin
        n_checks            = 0;
        n_pass              = 0;
        user_rst_n          = 1'b0;
        bus.link_up_raw     = 1'b0;
        bus.tx_valid        = 1'b0;
        bus.tx_end_of_frame = 1'b0;
        bus.tx_overflow     = 1'b0;
        bus.tx_afull        = 1'b0;
        bus.rx_valid        = 1'b0;
        bus.rx_end_of_frame = 1'b0;
        bus.rx_bad_frame    = 1'b0;
        bus.rx_overrun      = 1'b0;
        bus.sw_clr          = 1'b0;

        #12;
        check("rst_link_ok", {31'd0, bus.link_ok}, 32'd0);
        check("rst_status", bus.status_word, 32'd0);
        user_rst_n = 1'b1;
        steps(4);
        check("idle_status", bus.status_word, 32'd0);

        bus.link_up_raw = 1'b1;
        wait_link(n);
        check("debounce_latency", 32'(n), 32'd16);
        check("pre_snap_status", bus.status_word, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.status_word !== 32'd0) break;
        end
        check("first_up_snap", bus.status_word, 32'h8000_0000);

        bus.link_up_raw = 1'b0;
        async_reset("rst1");
        step();
        bus.link_up_raw = 1'b1;
        steps(10);
        bus.link_up_raw = 1'b0;
        step();
        check("abort_link_ok", {31'd0, bus.link_ok}, 32'd0);
        bus.link_up_raw = 1'b1;
        wait_link(n);
        check("abort_latency", 32'(n), 32'd16);
        steps(9);
        check("abort_snap", bus.status_word, 32'h8000_0000);

        tx_eof(1'b1);
        for (int i = 0; i < 5000; i++) begin
            bus.rx_valid        = (i < 3);
            bus.rx_end_of_frame = (i < 3);
            bus.rx_bad_frame    = (i == 0);
            step();
        end
        tx_eof(1'b0);
        bus.rx_valid        = 1'b0;
        bus.rx_end_of_frame = 1'b0;
        bus.rx_bad_frame    = 1'b0;
        steps(9);
        check("sat_counts", bus.status_word, 32'h90FF_F003);

        for (int d = 0; d < 9; d++) begin
            bus.link_up_raw = 1'b0;
            step();
            check($sformatf("drop%0d_link_ok", d), {31'd0, bus.link_ok}, 32'd0);
            bus.link_up_raw = 1'b1;
            wait_link(n);
            check($sformatf("drop%0d_relink", d), 32'(n), 32'd16);
        end
        steps(9);
        check("flap_sat", bus.status_word, 32'h97FF_F003);

        bus.tx_overflow = 1'b1;
        step();
        bus.tx_overflow = 1'b0;
        steps(9);
        check("tx_ovf_flag", bus.status_word, 32'hD7FF_F003);

        bus.sw_clr = 1'b1;
        tx_eof(1'b1);
        step();
        tx_eof(1'b0);
        check("clr_plus1", bus.status_word, 32'hD7FF_F003);
        step();
        check("clr_plus2", bus.status_word, 32'h8000_0000);
        check("clr_link_ok", {31'd0, bus.link_ok}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tx_eof(i < 2);
            bus.rx_overrun = (i == 2);
            step();
        end
        tx_eof(1'b0);
        bus.rx_overrun = 1'b0;
        bus.sw_clr     = 1'b0;
        steps(9);
        check("clr_once", bus.status_word, 32'hA000_2000);

        tx_eof(1'b1);
        steps(3);
        check("pre_rst2_link_ok", {31'd0, bus.link_ok}, 32'd1);
        async_reset("rst2");
        tx_eof(1'b0);
        wait_link(n);
        check("rst2_relink", 32'(n), 32'd16);

        bus.link_up_raw = 1'b0;
        step();
        bus.link_up_raw = 1'b1;
        steps(8);
        async_reset("rst3");
        wait_link(n);
        check("rst3_relink", 32'(n), 32'd16);
        steps(9);
        check("rst3_snap", bus.status_word, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
